// File: rtl/tmds_channel_decoder.sv
// TMDS receive lane: recovers 10-bit symbol alignment by bit-slipping until a
// run of control tokens is seen, then decodes data bytes and control values.
module tmds_channel_decoder #(
    parameter int LOCK_COUNT     = 8,
    parameter int SEARCH_TIMEOUT = 2048
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] raw_bits,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       de,
    output logic       locked,
    output logic [3:0] offset,
    output logic       slip
);
    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam int TMR_W = $clog2(SEARCH_TIMEOUT);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_COUNT);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(SEARCH_TIMEOUT - 1);

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Returns {is_token, ctrl_value}.
    function automatic logic [2:0] token_decode(input logic [9:0] sym);
        logic [2:0] r;
        case (sym)
            10'b1101010100: r = 3'b100;
            10'b0010101011: r = 3'b101;
            10'b0101010100: r = 3'b110;
            10'b1010101011: r = 3'b111;
            default:        r = 3'b000;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] data_decode(input logic [9:0] sym);
        logic [7:0] qm;
        logic [7:0] d;
        qm   = sym[9] ? ~sym[7:0] : sym[7:0];
        d    = 8'd0;
        d[0] = qm[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = sym[8] ? (qm[i] ^ qm[i-1]) : ~(qm[i] ^ qm[i-1]);
        end
        return d;
    endfunction

    state_t           state_q, state_d;
    logic [9:0]       prev_q, prev_d;
    logic [9:0]       sym_q, sym_d;
    logic             stale_q, stale_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [3:0]       offset_q, offset_d;
    logic             slip_q, slip_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic             de_q, de_d;

    logic [19:0]      win_s;
    logic [2:0]       tok_s;
    logic             reach_s;
    logic             timeout_s;

    // Alignment search, lock tracking and output decode.
    always_comb begin
        win_s     = {raw_bits, prev_q};
        prev_d    = raw_bits;
        sym_d     = win_s[offset_q +: 10];
        tok_s     = token_decode(sym_q);
        state_d   = state_q;
        offset_d  = offset_q;
        slip_d    = 1'b0;
        stale_d   = 1'b0;
        timer_d   = timer_q + TMR_W'(1);
        data_d    = 8'd0;
        ctrl_d    = 2'd0;
        de_d      = 1'b0;

        // The first symbol captured after a slip still used the old offset.
        if (tok_s[2] && !stale_q) begin
            run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
        end else begin
            run_d = {RUN_W{1'b0}};
        end
        reach_s   = (run_d == RUN_MAX);
        timeout_s = (timer_q == TMR_MAX);

        if (reach_s) begin
            timer_d = {TMR_W{1'b0}};
            state_d = ST_LOCKED;
        end else if (timeout_s) begin
            run_d   = {RUN_W{1'b0}};
            timer_d = {TMR_W{1'b0}};
            if (state_q == ST_SEARCH) begin
                offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
                slip_d   = 1'b1;
                stale_d  = 1'b1;
            end else begin
                state_d = ST_SEARCH;
            end
        end else begin
            state_d = state_q;
        end

        if (state_d == ST_LOCKED) begin
            if (tok_s[2]) begin
                ctrl_d = tok_s[1:0];
            end else begin
                de_d   = 1'b1;
                data_d = data_decode(sym_q);
                ctrl_d = ctrl_q;
            end
        end else begin
            de_d = 1'b0;
        end
    end

    // State and pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_SEARCH;
            prev_q   <= 10'd0;
            sym_q    <= 10'd0;
            stale_q  <= 1'b0;
            run_q    <= {RUN_W{1'b0}};
            timer_q  <= {TMR_W{1'b0}};
            offset_q <= 4'd0;
            slip_q   <= 1'b0;
            data_q   <= 8'd0;
            ctrl_q   <= 2'd0;
            de_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            sym_q    <= sym_d;
            stale_q  <= stale_d;
            run_q    <= run_d;
            timer_q  <= timer_d;
            offset_q <= offset_d;
            slip_q   <= slip_d;
            data_q   <= data_d;
            ctrl_q   <= ctrl_d;
            de_q     <= de_d;
        end
    end

    assign data   = data_q;
    assign ctrl   = ctrl_q;
    assign de     = de_q;
    assign locked = (state_q == ST_LOCKED);
    assign offset = offset_q;
    assign slip   = slip_q;
endmodule
